// File: rtl/wb_stage_if.sv
// MEM-to-WB bus: incoming instruction, data-memory response, and register-file/forwarding outputs.
interface wb_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic              in_reg_write;
  logic [ADDR_W-1:0] in_dest;
  logic [DATA_W-1:0] in_alu_result;
  logic              in_mem_to_reg;
  logic [1:0]        in_load_size;
  logic              in_load_unsigned;
  logic              flush;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic              RegWrite;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic              fwd_valid;
  logic [ADDR_W-1:0] fwd_addr;
  logic [DATA_W-1:0] fwd_data;

  modport slave (
    input  in_valid, in_reg_write, in_dest, in_alu_result, in_mem_to_reg,
           in_load_size, in_load_unsigned, flush, mem_rdata, mem_rvalid,
    output in_ready, RegWrite, write_addr, write_data, fwd_valid, fwd_addr, fwd_data
  );

  modport master (
    output in_valid, in_reg_write, in_dest, in_alu_result, in_mem_to_reg,
           in_load_size, in_load_unsigned, flush, mem_rdata, mem_rvalid,
    input  in_ready, RegWrite, write_addr, write_data, fwd_valid, fwd_addr, fwd_data
  );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline register: aligns load data, waits on slow memory and drives the
// register-file write port plus a persistent forwarding entry.
module wb_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input logic       clk,
  input logic       rst,
  wb_stage_if.slave bus
);

  localparam logic StIdle    = 1'b0;
  localparam logic StWaitMem = 1'b1;

  function automatic logic [DATA_W-1:0] align_load(input logic [DATA_W-1:0] rdata,
                                                   input logic [1:0]        off,
                                                   input logic [1:0]        size,
                                                   input logic              uns);
    logic [7:0]  b;
    logic [15:0] h;
    unique case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   return {{(DATA_W-8){~uns & b[7]}}, b};
      2'b01:   return {{(DATA_W-16){~uns & h[15]}}, h};
      default: return rdata;
    endcase
  endfunction

  logic              state_q, state_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              rw_q, rw_d;

  logic              regwrite_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              fwd_valid_q;
  logic [ADDR_W-1:0] fwd_addr_q;
  logic [DATA_W-1:0] fwd_data_q;

  logic              commit;
  logic              c_rw;
  logic [ADDR_W-1:0] c_dest;
  logic [DATA_W-1:0] c_data;
  logic              ready;

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rw_d    = rw_q;
    commit  = 1'b0;
    c_rw    = 1'b0;
    c_dest  = '0;
    c_data  = '0;
    ready   = (state_q == StIdle);
    case (state_q)
      StIdle: begin
        if (bus.in_valid && !bus.flush) begin
          if (!bus.in_mem_to_reg) begin
            commit = 1'b1;
            c_rw   = bus.in_reg_write;
            c_dest = bus.in_dest;
            c_data = bus.in_alu_result;
          end else if (bus.mem_rvalid) begin
            commit = 1'b1;
            c_rw   = bus.in_reg_write;
            c_dest = bus.in_dest;
            c_data = align_load(bus.mem_rdata, bus.in_alu_result[1:0], bus.in_load_size,
                                bus.in_load_unsigned);
          end else begin
            state_d = StWaitMem;
            dest_d  = bus.in_dest;
            off_d   = bus.in_alu_result[1:0];
            size_d  = bus.in_load_size;
            uns_d   = bus.in_load_unsigned;
            rw_d    = bus.in_reg_write;
          end
        end
      end
      StWaitMem: begin
        // Flush wins over a response arriving in the same cycle.
        if (bus.flush) begin
          state_d = StIdle;
        end else if (bus.mem_rvalid) begin
          state_d = StIdle;
          commit  = 1'b1;
          c_rw    = rw_q;
          c_dest  = dest_q;
          c_data  = align_load(bus.mem_rdata, off_q, size_q, uns_q);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      dest_q      <= '0;
      off_q       <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      rw_q        <= 1'b0;
      regwrite_q  <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      dest_q     <= dest_d;
      off_q      <= off_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      rw_q       <= rw_d;
      regwrite_q <= commit & c_rw & (c_dest != '0);
      if (commit) begin
        waddr_q <= c_dest;
        wdata_q <= c_data;
      end
      if (commit && c_rw) begin
        fwd_valid_q <= (c_dest != '0);
        fwd_addr_q  <= c_dest;
        fwd_data_q  <= c_data;
      end
    end
  end

  assign bus.in_ready   = ready;
  assign bus.RegWrite   = regwrite_q;
  assign bus.write_addr = waddr_q;
  assign bus.write_data = wdata_q;
  assign bus.fwd_valid  = fwd_valid_q;
  assign bus.fwd_addr   = fwd_addr_q;
  assign bus.fwd_data   = fwd_data_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed-vector bench for wb_stage: ALU writes, r0 suppression, load alignment,
// slow loads, flush and reset during a memory wait.
module tb_wb_stage;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  wb_stage_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] dest,
                       input logic [31:0] alu, input logic m2r, input logic [1:0] size,
                       input logic uns, input logic [31:0] rdata, input logic rvalid);
    bus.in_valid         = v;
    bus.in_reg_write     = rw;
    bus.in_dest          = dest;
    bus.in_alu_result    = alu;
    bus.in_mem_to_reg    = m2r;
    bus.in_load_size     = size;
    bus.in_load_unsigned = uns;
    bus.mem_rdata        = rdata;
    bus.mem_rvalid       = rvalid;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 2'b10, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.flush = 1'b0;
    idle();
    #12;
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_regwrite", {31'b0, bus.RegWrite}, 32'd0);
    check("rst_waddr", {27'b0, bus.write_addr}, 32'd0);
    check("rst_wdata", bus.write_data, 32'h0);
    check("rst_fwd_valid", {31'b0, bus.fwd_valid}, 32'd0);
    check("rst_fwd_data", bus.fwd_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // ALU write
    drive(1'b1, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 2'b10, 1'b0, 32'h0, 1'b0);
    step();
    check("alu_regwrite", {31'b0, bus.RegWrite}, 32'd1);
    check("alu_waddr", {27'b0, bus.write_addr}, 32'd5);
    check("alu_wdata", bus.write_data, 32'h1234_5678);
    check("alu_fwd_valid", {31'b0, bus.fwd_valid}, 32'd1);
    check("alu_fwd_addr", {27'b0, bus.fwd_addr}, 32'd5);
    check("alu_fwd_data", bus.fwd_data, 32'h1234_5678);
    idle();
    step();
    check("alu_pulse_end", {31'b0, bus.RegWrite}, 32'd0);
    check("alu_fwd_persist", {31'b0, bus.fwd_valid}, 32'd1);

    // r0 suppression
    drive(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 2'b10, 1'b0, 32'h0, 1'b0);
    step();
    check("r0_regwrite", {31'b0, bus.RegWrite}, 32'd0);
    check("r0_fwd_valid", {31'b0, bus.fwd_valid}, 32'd0);

    // Byte loads, offset 3
    drive(1'b1, 1'b1, 5'd7, 32'h0000_1003, 1'b1, 2'b00, 1'b0, 32'h80AA_BBCC, 1'b1);
    step();
    check("lb_off3_regwrite", {31'b0, bus.RegWrite}, 32'd1);
    check("lb_off3_wdata", bus.write_data, 32'hFFFF_FF80);
    drive(1'b1, 1'b1, 5'd7, 32'h0000_1003, 1'b1, 2'b00, 1'b1, 32'h80AA_BBCC, 1'b1);
    step();
    check("lbu_off3_wdata", bus.write_data, 32'h0000_0080);
    drive(1'b1, 1'b1, 5'd7, 32'h0000_1001, 1'b1, 2'b00, 1'b0, 32'h80AA_BBCC, 1'b1);
    step();
    check("lb_off1_wdata", bus.write_data, 32'hFFFF_FFBB);

    // Half loads
    drive(1'b1, 1'b1, 5'd8, 32'h0000_2002, 1'b1, 2'b01, 1'b0, 32'h8001_7FFF, 1'b1);
    step();
    check("lh_off2_wdata", bus.write_data, 32'hFFFF_8001);
    drive(1'b1, 1'b1, 5'd8, 32'h0000_2000, 1'b1, 2'b01, 1'b0, 32'h8001_7FFF, 1'b1);
    step();
    check("lh_off0_wdata", bus.write_data, 32'h0000_7FFF);
    check("lh_fwd_addr", {27'b0, bus.fwd_addr}, 32'd8);

    // Slow word load
    drive(1'b1, 1'b1, 5'd9, 32'h0000_3000, 1'b1, 2'b10, 1'b0, 32'h0, 1'b0);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("slow_ready_%0d", i), {31'b0, bus.in_ready}, 32'd0);
      check($sformatf("slow_nowrite_%0d", i), {31'b0, bus.RegWrite}, 32'd0);
      if (i < 2) step();
    end
    bus.mem_rdata  = 32'hDEAD_BEEF;
    bus.mem_rvalid = 1'b1;
    step();
    check("slow_regwrite", {31'b0, bus.RegWrite}, 32'd1);
    check("slow_waddr", {27'b0, bus.write_addr}, 32'd9);
    check("slow_wdata", bus.write_data, 32'hDEAD_BEEF);
    check("slow_ready_back", {31'b0, bus.in_ready}, 32'd1);
    idle();
    step();
    check("slow_pulse_end", {31'b0, bus.RegWrite}, 32'd0);

    // Flush in WAIT_MEM; a late response is ignored
    drive(1'b1, 1'b1, 5'd10, 32'h0000_4000, 1'b1, 2'b10, 1'b0, 32'h0, 1'b0);
    step();
    idle();
    check("fl_wait_ready", {31'b0, bus.in_ready}, 32'd0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("fl_ready", {31'b0, bus.in_ready}, 32'd1);
    check("fl_nowrite", {31'b0, bus.RegWrite}, 32'd0);
    bus.mem_rdata  = 32'h1111_2222;
    bus.mem_rvalid = 1'b1;
    step();
    idle();
    check("fl_late_rvalid", {31'b0, bus.RegWrite}, 32'd0);
    check("fl_fwd_addr", {27'b0, bus.fwd_addr}, 32'd9);
    check("fl_fwd_data", bus.fwd_data, 32'hDEAD_BEEF);

    // Flush concurrent with acceptance
    drive(1'b1, 1'b1, 5'd4, 32'h0BAD_F00D, 1'b0, 2'b10, 1'b0, 32'h0, 1'b0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    idle();
    check("flacc_nowrite", {31'b0, bus.RegWrite}, 32'd0);
    check("flacc_fwd_valid", {31'b0, bus.fwd_valid}, 32'd1);
    check("flacc_fwd_addr", {27'b0, bus.fwd_addr}, 32'd9);

    // Reset mid-wait
    drive(1'b1, 1'b1, 5'd11, 32'h0000_5000, 1'b1, 2'b10, 1'b0, 32'h0, 1'b0);
    step();
    idle();
    check("rw_wait_ready", {31'b0, bus.in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("rw_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rw_fwd_valid", {31'b0, bus.fwd_valid}, 32'd0);
    check("rw_fwd_data", bus.fwd_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.mem_rdata  = 32'hCAFE_0001;
    bus.mem_rvalid = 1'b1;
    step();
    idle();
    check("rw_nowrite", {31'b0, bus.RegWrite}, 32'd0);
    check("rw_wdata", bus.write_data, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register and writeback driver for the MIPS core.
- Produces the register-file write port: RegWrite, write_addr, write_data.
- Aligns and sign/zero-extends load data, and waits on slow data memory with a two-state FSM.
- Exports forwarding info, because the register file reads synchronously and cannot return same-cycle written data.

Parameters:
- DATA_W, 32, datapath width
- ADDR_W, 5, register address width

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  MEM stage presents an instruction this cycle
- in_ready  output  1  wb_stage accepts the MEM-stage instruction this cycle
- in_reg_write  input  1  instruction writes a register
- in_dest  input  5  destination register
- in_alu_result  input  32  ALU result; bits [1:0] are the byte offset for loads
- in_mem_to_reg  input  1  1 = load, 0 = ALU result
- in_load_size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- in_load_unsigned  input  1  1 = zero-extend, 0 = sign-extend
- flush  input  1  kill the instruction held in the stage
- mem_rdata  input  32  data-memory read data
- mem_rvalid  input  1  mem_rdata valid this cycle
- RegWrite  output  1  register-file write enable
- write_addr  output  5  register-file write address
- write_data  output  32  register-file write data
- fwd_valid  output  1  forwarding entry valid
- fwd_addr  output  5  forwarding destination
- fwd_data  output  32  forwarding data

Behaviour:
- Reset (async, rst=1): state=IDLE; RegWrite=0; write_addr=0; write_data=0; fwd_valid=0; fwd_addr=0; fwd_data=0; in_ready=1.
- FSM states: IDLE, WAIT_MEM.
- in_ready=1 in IDLE; in_ready=0 in WAIT_MEM.

IDLE, in_valid & in_ready & !flush:
- Non-load (in_mem_to_reg=0): next edge drives RegWrite = in_reg_write & (in_dest!=0), write_addr=in_dest, write_data=in_alu_result. Latency is 1 cycle; stay in IDLE.
- Load with mem_rvalid=1 in the accept cycle: data is aligned and written on the next edge. Latency is 1 cycle.
- Load with mem_rvalid=0: capture dest, offset, size and unsigned flag; go to WAIT_MEM. RegWrite=0 next cycle.

WAIT_MEM:
- Each cycle mem_rvalid=0: hold state, RegWrite=0.
- First cycle mem_rvalid=1: next edge drives the aligned write and returns to IDLE.
- Any later mem_rvalid is ignored.

Flush:
- In WAIT_MEM: return to IDLE with no write.
- Concurrent with acceptance in IDLE: the instruction is dropped.

RegWrite pulse rules:
- RegWrite is a single-cycle pulse.
- RegWrite is never 1 for write_addr=0, even when in_reg_write=1.

Load alignment, with off = address bits [1:0]:
- Byte: select byte lane off (off=0 selects bits [7:0], off=3 selects bits [31:24]), then extend from bit 7.
- Half: lane off[1] (0 selects [15:0], 1 selects [31:16]), extend from bit 15. off[0] is ignored.
- Word: pass through.

Forwarding:
- Each write updates fwd_valid/fwd_addr/fwd_data in the same cycle as RegWrite, to the same values.
- The entry persists until the next write or reset.
- A flush does not clear an already-committed entry.
- A write with dest 0 sets fwd_valid=0.

Reset mid-WAIT_MEM: go to IDLE immediately; the pending write is lost.

Test Plan:
- ALU write: in_dest=5, alu=0x1234_5678, reg_write=1 -> next cycle RegWrite=1, write_addr=5, write_data=0x1234_5678, fwd_valid=1, fwd_addr=5.
- r0 suppression: in_dest=0, reg_write=1, alu=0xFFFF_FFFF -> RegWrite stays 0, fwd_valid=0.
- Signed byte load, offset 3, mem_rdata=0x80AA_BBCC, mem_rvalid=1 at accept -> write_data=0xFFFF_FF80. With unsigned=1 -> 0x0000_0080.
- Half load, offset 2, mem_rdata=0x8001_7FFF, signed -> write_data=0xFFFF_8001. Offset 0 -> 0x0000_7FFF.
- Slow load: mem_rvalid low for 3 cycles -> in_ready=0 for 3 cycles. mem_rvalid=1 with 0xDEAD_BEEF, word, dest 9 -> one RegWrite pulse next cycle, in_ready=1.
- Flush in WAIT_MEM, and rst asserted mid-wait -> no RegWrite, state IDLE, in_ready=1. An earlier fwd entry is unchanged after flush and cleared by rst.
